// File: rtl/montgomery_exp_sequencer.sv
// Montgomery exponentiation command sequencer: walks the exponent MSB-first
// and issues READ / SQUARE / MULTIPLY / WRITE words to the Montgomery wrapper.
module montgomery_exp_sequencer #(
   parameter int EXP_BITS = 32,
   parameter int LEN_W    = 6
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [EXP_BITS-1:0] exp_in,
   input  logic [LEN_W-1:0]    exp_len,
   output logic [31:0]         cmd_dout,
   output logic                cmd_valid,
   input  logic                cmd_read,
   input  logic                done_valid,
   output logic                done_read,
   output logic                busy,
   output logic                done,
   output logic [15:0]         cmd_count,
   output logic                protocol_err
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      ACK,
      NEXT,
      FINISH
   } state_e;

   localparam logic [5:0] CMD_READ = 6'h00;
   localparam logic [5:0] CMD_SQR  = 6'h01;
   localparam logic [5:0] CMD_MUL  = 6'h11;
   localparam logic [5:0] CMD_WR   = 6'h02;

   localparam logic [LEN_W-1:0]    MAX_LEN = LEN_W'(EXP_BITS);
   localparam logic [EXP_BITS-1:0] ONE     = EXP_BITS'(1);

   state_e              state_q, state_d;
   logic [EXP_BITS-1:0] exp_q, exp_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    bit_q, bit_d;
   logic [5:0]          cmd_q, cmd_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                perr_q, perr_d;
   logic                cur_bit;

   assign cur_bit = |(exp_q & (ONE << bit_q));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         exp_q   <= '0;
         len_q   <= '0;
         bit_q   <= '0;
         cmd_q   <= '0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         len_q   <= len_d;
         bit_q   <= bit_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      len_d   = len_q;
      bit_d   = bit_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      perr_d  = perr_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               exp_d   = exp_in;
               len_d   = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;
               bit_d   = '0;
               cmd_d   = CMD_READ;
               cnt_d   = '0;
               perr_d  = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // acceptance wins over a simultaneous done_valid
            if (cmd_read) begin
               state_d = WAIT_DONE;
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end else if (done_valid) begin
               perr_d = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (done_valid) state_d = ACK;
         end
         ACK: begin
            state_d = NEXT;
         end
         NEXT: begin
            state_d = ISSUE;
            unique case (cmd_q)
               CMD_READ: begin
                  if (len_q == '0) begin
                     cmd_d = CMD_WR;
                  end else begin
                     cmd_d = CMD_SQR;
                     bit_d = len_q - 1'b1;
                  end
               end
               CMD_SQR: begin
                  if (cur_bit) begin
                     cmd_d = CMD_MUL;
                  end else if (bit_q == '0) begin
                     cmd_d = CMD_WR;
                  end else begin
                     bit_d = bit_q - 1'b1;
                  end
               end
               CMD_MUL: begin
                  if (bit_q == '0) begin
                     cmd_d = CMD_WR;
                  end else begin
                     cmd_d = CMD_SQR;
                     bit_d = bit_q - 1'b1;
                  end
               end
               default: state_d = FINISH;
            endcase
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_dout     = {26'd0, cmd_q};
   assign cmd_valid    = (state_q == ISSUE);
   assign done_read    = (state_q == ACK);
   assign done         = (state_q == FINISH);
   assign busy         = (state_q == ISSUE) || (state_q == WAIT_DONE) ||
                         (state_q == ACK)   || (state_q == NEXT);
   assign cmd_count    = cnt_q;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_montgomery_exp_sequencer.sv
// Bench for montgomery_exp_sequencer: a wrapper model drives the handshake
// and observed command streams are compared against a square-and-multiply list.
module tb_montgomery_exp_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [31:0] exp_in = '0;
   logic [5:0]  exp_len = '0;
   logic        cmd_read = 1'b0;
   logic        done_valid = 1'b0;
   logic [31:0] cmd_dout;
   logic        cmd_valid;
   logic        done_read;
   logic        busy;
   logic        done;
   logic [15:0] cmd_count;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_cmds[$];
   logic [31:0] obs_cmds[$];
   int   ndone, stab_bad, cnt_bad, tmo;
   logic perr_seen, dread_seen, abort_or;

   always #5 clk = ~clk;

   montgomery_exp_sequencer #(.EXP_BITS(32), .LEN_W(6)) dut (
      .clk(clk),
      .resetn(resetn),
      .start(start),
      .exp_in(exp_in),
      .exp_len(exp_len),
      .cmd_dout(cmd_dout),
      .cmd_valid(cmd_valid),
      .cmd_read(cmd_read),
      .done_valid(done_valid),
      .done_read(done_read),
      .busy(busy),
      .done(done),
      .cmd_count(cmd_count),
      .protocol_err(protocol_err)
   );

   // square-and-multiply ladder from the exponent, MSB first
   function automatic void model(input logic [31:0] e, input int l);
      int eff;
      eff = (l > 32) ? 32 : l;
      exp_cmds.delete();
      exp_cmds.push_back(32'h00);
      for (int i = eff - 1; i >= 0; i--) begin
         exp_cmds.push_back(32'h01);
         if (e[i]) exp_cmds.push_back(32'h11);
      end
      exp_cmds.push_back(32'h02);
   endfunction

   function automatic int seq_diff();
      if (obs_cmds.size() != exp_cmds.size()) return 9999;
      for (int i = 0; i < obs_cmds.size(); i++)
         if (obs_cmds[i] !== exp_cmds[i]) return i;
      return -1;
   endfunction

   task automatic run_seq(input logic [31:0] e, input logic [5:0] l,
                          input int hmin, input int hmax, input int resp,
                          input bit inject, input int abort_at);
      int w, hold;
      bit fin;
      logic [31:0] first;
      obs_cmds.delete();
      ndone = 0; stab_bad = 0; cnt_bad = 0; tmo = 0;
      perr_seen = 0; dread_seen = 0; abort_or = 1; fin = 0;
      @(negedge clk);
      exp_in = e; exp_len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0; exp_in = $urandom; exp_len = 6'($urandom);
      while (!fin && tmo == 0) begin
         w = 0;
         while (!cmd_valid && !done && w < 40) begin
            @(negedge clk); w++;
         end
         if (done) begin
            ndone++;
            @(negedge clk);
            if (done || busy) ndone++;
            fin = 1;
         end else if (!cmd_valid || obs_cmds.size() > 200) begin
            tmo = 1;
         end else if (abort_at == obs_cmds.size() + 1) begin
            resetn = 1'b0;
            #1;
            abort_or = |{cmd_dout, cmd_valid, done_read, busy,
                         done, cmd_count, protocol_err};
            repeat (3) begin
               @(negedge clk);
               if (done) ndone++;
            end
            resetn = 1'b1;
            fin = 1;
         end else begin
            first = cmd_dout;
            hold = $urandom_range(hmin, hmax);
            if (inject && obs_cmds.size() == 0) begin
               done_valid = 1'b1; start = 1'b1;
               exp_in = ~e; exp_len = 6'd3;
               @(negedge clk);
               done_valid = 1'b0; start = 1'b0;
               perr_seen = protocol_err;
               dread_seen = done_read;
               if (!cmd_valid || cmd_dout !== first) stab_bad++;
            end
            repeat (hold) begin
               @(negedge clk);
               if (!cmd_valid || cmd_dout !== first ||
                   cmd_count != 16'(obs_cmds.size())) stab_bad++;
            end
            cmd_read = 1'b1;
            obs_cmds.push_back(cmd_dout);
            @(negedge clk);
            cmd_read = 1'b0;
            if (cmd_count != 16'(obs_cmds.size()) || cmd_valid) cnt_bad++;
            repeat (resp) @(negedge clk);
            done_valid = 1'b1;
            w = 0;
            do begin
               @(negedge clk); w++;
            end while (!done_read && w < 40);
            done_valid = 1'b0;
            if (!done_read) tmo = 1;
         end
      end
   endtask

   task automatic test_reset();
      logic [53:0] o;
      o = {cmd_dout, cmd_valid, done_read, busy, done, cmd_count, protocol_err};
      checks++;
      if (o !== '0) begin
         errors++; $display("FAIL reset_held: outputs=%h want 0", o);
      end
      resetn = 1'b1;
      @(negedge clk); @(negedge clk);
      o = {cmd_dout, cmd_valid, done_read, busy, done, cmd_count, protocol_err};
      checks++;
      if (o !== '0) begin
         errors++; $display("FAIL reset_idle: outputs=%h want 0", o);
      end
   endtask

   task automatic check_run(input string nm, input int cnt);
      int d;
      d = seq_diff();
      checks++;
      if (d != -1 || tmo != 0) begin
         errors++;
         $display("FAIL %s_seq: got %0d cmds want %0d, diff at %0d tmo=%0d",
                  nm, obs_cmds.size(), exp_cmds.size(), d, tmo);
      end
      checks++;
      if (ndone != 1) begin
         errors++; $display("FAIL %s_done: pulses=%0d want 1", nm, ndone);
      end
      checks++;
      if (cmd_count !== 16'(cnt)) begin
         errors++; $display("FAIL %s_count: got %0d want %0d", nm, cmd_count, cnt);
      end
      checks++;
      if (stab_bad != 0 || cnt_bad != 0) begin
         errors++;
         $display("FAIL %s_hs: unstable=%0d badcount=%0d want 0", nm, stab_bad, cnt_bad);
      end
   endtask

   task automatic test_pattern_b();
      model(32'hB, 4);
      run_seq(32'hB, 6'd4, 0, 0, 3, 0, 0);
      check_run("patB", 9);
      checks++;
      if (exp_cmds.size() != 9 || exp_cmds[2] !== 32'h11) begin
         errors++; $display("FAIL patB_model: size=%0d want 9", exp_cmds.size());
      end
   endtask

   task automatic test_len_zero();
      model(32'hDEAD_BEEF, 0);
      run_seq(32'hDEAD_BEEF, 6'd0, 0, 1, 2, 0, 0);
      check_run("len0", 2);
   endtask

   task automatic test_hold();
      model(32'h5, 3);
      run_seq(32'h5, 6'd3, 5, 5, 1, 0, 0);
      check_run("hold5", exp_cmds.size());
   endtask

   task automatic test_clamp();
      model(32'hFFFF_FFFF, 40);
      run_seq(32'hFFFF_FFFF, 6'd40, 0, 0, 0, 0, 0);
      check_run("clamp", 66);
   endtask

   task automatic test_protocol();
      model(32'h6, 3);
      run_seq(32'h6, 6'd3, 1, 2, 2, 1, 0);
      check_run("perr", exp_cmds.size());
      checks++;
      if (perr_seen !== 1'b1 || dread_seen !== 1'b0) begin
         errors++;
         $display("FAIL perr_flag: perr=%b dread=%b want 1 0", perr_seen, dread_seen);
      end
      checks++;
      if (protocol_err !== 1'b1) begin
         errors++; $display("FAIL perr_sticky: got %b want 1", protocol_err);
      end
   endtask

   task automatic test_reset_mid();
      run_seq(32'hB, 6'd4, 0, 2, 3, 0, 4);
      checks++;
      if (abort_or !== 1'b0 || obs_cmds.size() != 3) begin
         errors++;
         $display("FAIL mid_reset: outs_or=%b cmds=%0d want 0 3", abort_or, obs_cmds.size());
      end
      checks++;
      if (ndone != 0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_resume: done=%0d busy=%b valid=%b want 0", ndone, busy, cmd_valid);
      end
      model(32'hB, 4);
      run_seq(32'hB, 6'd4, 0, 1, 3, 0, 0);
      check_run("after_rst", 9);
   endtask

   task automatic test_back_to_back();
      model(32'h3, 2);
      run_seq(32'h3, 6'd2, 0, 0, 1, 0, 0);
      checks++;
      if (protocol_err !== 1'b0) begin
         errors++; $display("FAIL b2b_perr_clear: got %b want 0", protocol_err);
      end
      check_run("b2b_a", exp_cmds.size());
      model(32'h8000_0001, 32);
      run_seq(32'h8000_0001, 6'd32, 0, 0, 1, 0, 0);
      check_run("b2b_b", exp_cmds.size());
   endtask

   task automatic test_random();
      logic [31:0] e;
      int l;
      for (int k = 0; k < 8; k++) begin
         e = $urandom;
         l = $urandom_range(0, 40);
         model(e, l);
         run_seq(e, 6'(l), 0, 3, $urandom_range(0, 4), 0, 0);
         check_run($sformatf("rand%0d", k), exp_cmds.size());
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_pattern_b();
      test_len_zero();
      test_hold();
      test_clamp();
      test_protocol();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/montgomery_exp_sequencer.md
MONTGOMERY_EXP_SEQUENCER -- requirements
Module: montgomery_exp_sequencer

Interface
REQ-001 SHALL have parameter EXP_BITS, default 32: maximum exponent length in bits.
REQ-002 SHALL have parameter LEN_W, default 6: width of exp_len; must satisfy 2^LEN_W > EXP_BITS.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to begin one exponentiation.
REQ-006 exp_in  in  EXP_BITS  exponent; sampled when start is accepted.
REQ-007 exp_len  in  LEN_W  number of significant exponent bits; sampled when start is accepted.
REQ-008 cmd_dout  out  32  command word to the Montgomery wrapper command port (port1).
REQ-009 cmd_valid  out  1  cmd_dout is valid.
REQ-010 cmd_read  in  1  wrapper has accepted cmd_dout (port1_read).
REQ-011 done_valid  in  1  wrapper has completed the current command (port2_valid).
REQ-012 done_read  out  1  acknowledges done_valid (port2_read).
REQ-013 busy  out  1  high from start acceptance until the done pulse.
REQ-014 done  out  1  single-cycle pulse when the final WRITE completes.
REQ-015 cmd_count  out  16  commands accepted since the last start.
REQ-016 protocol_err  out  1  sticky flag: done_valid was seen while a command was still unaccepted.

Function
REQ-017 cmd_dout[1:0] SHALL be the opcode: 0 READ, 1 COMPUTE, 2 WRITE.
REQ-018 cmd_dout[3:2] SHALL select operand A and cmd_dout[5:4] operand B (0 = ACC, 1 = BASE); cmd_dout[31:6] SHALL be 0.
REQ-019 The following command words SHALL be used: READ 0x00, SQUARE 0x01, MULTIPLY 0x11, WRITE 0x02.
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT_DONE, ACK, NEXT and FINISH.
REQ-021 In IDLE, start=1 SHALL:
- latch exp_in and eff_len = min(exp_len, EXP_BITS);
- clear cmd_count and protocol_err;
- set busy;
- move to ISSUE with cmd = READ.
REQ-022 cmd_valid SHALL first be 1 in the cycle after start.
REQ-023 In ISSUE, cmd_valid=1 and cmd_dout SHALL be held stable until cmd_read=1 is sampled at a clock edge.
REQ-024 On that edge, the block SHALL move to WAIT_DONE, drop cmd_valid and increment cmd_count.
REQ-025 In WAIT_DONE, done_valid=1 SHALL cause a move to ACK.
REQ-026 In ACK, done_read SHALL be 1 for exactly one cycle, followed by NEXT.
REQ-027 NEXT SHALL select the next command and return to ISSUE on the following cycle, in this order:
- after READ: SQUARE for bit eff_len-1, or WRITE if eff_len = 0;
- after SQUARE for bit i: MULTIPLY if exp bit i = 1, otherwise move to bit i-1;
- after MULTIPLY: SQUARE for bit i-1;
- after bit 0 is finished: WRITE;
- after WRITE: FINISH.
REQ-028 In FINISH, done SHALL be 1 for one cycle, busy SHALL drop in the same cycle, and the FSM SHALL then return to IDLE.
REQ-029 The exponent SHALL be scanned MSB-first using a down-counter of width LEN_W; there SHALL be no underflow past bit 0.
REQ-030 start SHALL be ignored when not in IDLE.
REQ-031 done_valid in ISSUE SHALL set protocol_err and SHALL NOT be acknowledged; the FSM SHALL stay in ISSUE.
REQ-032 cmd_read outside ISSUE SHALL be ignored.
REQ-033 If cmd_read and done_valid are both 1 in ISSUE, acceptance SHALL win: WAIT_DONE is entered and done_valid is evaluated on the next cycle.
REQ-034 cmd_count SHALL saturate at 0xFFFF.

Reset
REQ-035 resetn=0 SHALL immediately force IDLE and set to 0: cmd_dout, cmd_valid, done_read, busy, done, cmd_count, protocol_err and all internal registers.
REQ-036 A reset mid-operation SHALL abandon the sequence; nothing resumes after resetn rises.
REQ-037 The first start accepted after reset SHALL begin a fresh sequence.

Verification
REQ-038 exp_in=0xB, exp_len=4, wrapper responds 3 cycles after each accept -> cmd sequence 00,01,11,01,01,11,01,11,02; one done pulse; cmd_count=9.
REQ-039 exp_len=0 -> sequence 00,02 only; done pulse; cmd_count=2.
REQ-040 cmd_read held low for 5 cycles -> cmd_valid=1 and cmd_dout unchanged throughout; exactly one cmd_count increment on acceptance.
REQ-041 exp_in=0xFFFFFFFF, exp_len=40 -> clamped to 32; 66 commands (READ, 32×(01,11), WRITE); cmd_count=66.
REQ-042 done_valid pulsed during ISSUE -> protocol_err=1, no done_read; a second start while busy -> ignored.
REQ-043 resetn pulsed low during the 4th command -> all outputs 0 asynchronously, no done pulse; the next start yields the full sequence again.
